potential_decay_array: RTL and testbench
========================================

Name: potential_decay_array

Overview:
- Clocked, multi-neuron successor to the single-neuron combinational LIF decay stage.
- Holds NUM_NEURONS FP32 membrane potentials and a per-neuron 4-bit decay rate.
- On each timestep pulse, sweeps all neurons, one per cycle, through a pipelined exponent/significand decay datapath, writes results back and streams them out.
- Sits between the potential adder (which loads new potentials) and the spike/threshold stage.

Parameters:
NUM_NEURONS, 32, number of neurons held (2..4096)
ADDR_W, 5, neuron address width, must be at least clog2(NUM_NEURONS)
INIT_POTENTIAL, 32'h41DED852, reset value of every potential (FP32)
DEFAULT_RATE, 4'b0001, reset value of every decay rate

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
timestep_start  in  1  one-cycle pulse that starts a sweep; ignored while busy
busy  out  1  sweep in progress
done  out  1  one-cycle pulse when the last neuron is output
in_valid  in  1  new-potential write request from the adder
in_ready  out  1  equals ~busy
in_addr  in  ADDR_W  neuron index for the new potential
in_potential  in  32  new FP32 potential
cfg_we  in  1  decay-rate write; ignored while busy
cfg_addr  in  ADDR_W  neuron index for the rate write
cfg_decay_rate  in  4  rate code
out_valid  out  1  decayed potential valid
out_addr  out  ADDR_W  neuron index of out_potential
out_potential  out  32  decayed FP32 potential

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - Every potential loads INIT_POTENTIAL; every rate loads DEFAULT_RATE.
  - busy, done and out_valid go to 0; out_addr and out_potential go to 0; FSM returns to IDLE.
  - Reset mid-sweep aborts the sweep. No done pulse is produced.
- FSM: IDLE -> SWEEP -> IDLE.
  - IDLE: on timestep_start=1, go to SWEEP with the sweep pointer at 0.
  - SWEEP: the pointer increments each cycle until NUM_NEURONS-1; the pipeline then drains and the FSM returns to IDLE.
- Timing, with the start pulse sampled at the edge ending cycle 0:
  - busy is 1 in cycles 1..NUM_NEURONS+1.
  - Stage 1 reads neuron k in cycle k+1.
  - out_valid=1, out_addr=k and the decayed value appear in cycle k+2. The same value is written back into neuron k at the end of that cycle.
  - done=1 in cycle NUM_NEURONS+1, coincident with the output for neuron NUM_NEURONS-1.
  - busy=0 from cycle NUM_NEURONS+2. A new timestep_start is accepted in that cycle at the earliest.
- Writes:
  - in_valid && in_ready writes in_potential to in_addr at the clock edge.
  - cfg_we && !busy writes the rate.
  - Out-of-range addresses (at or above NUM_NEURONS) are dropped.
  - An in write and a cfg write in the same cycle to the same address both take effect.
  - A timestep_start in the same IDLE cycle as a write: the write lands first, and the sweep sees the new value.
- Decay arithmetic, for input {s,e,m}:
  - e==8'hFF (Inf/NaN): passed unchanged.
  - e==0 (zero/denormal): output {s,31'b0}.
  - 4'b0001 divides by 1: value unchanged.
  - 4'b0010, 4'b0100, 4'b1000 divide by 2, 4, 8: exponent reduced by d = 1, 2, 3, mantissa kept. If e<=d, output {s,31'b0}.
  - 4'b0011 multiplies by 0.75 (x/2+x/4), with no FP adder:
    - S = {1,m} (24 bits); T = S + (S<<1) (26 bits).
    - If T[25]=1: exponent e, mantissa T[24:2].
    - Else: exponent e-1, mantissa T[23:1]. If e-1==0, output {s,31'b0}.
    - Truncate, no rounding. Sign is preserved.
  - Any other code: treated as 4'b0001.
- out_potential and out_addr hold their last value when out_valid=0.

Test Plan:
- Reset, then cfg rate 4'b0010 on neuron 0, then start -> cycle 2: out_addr=0, out_potential=32'h415ED852. done in cycle NUM_NEURONS+1. Neurons with DEFAULT_RATE output 32'h41DED852.
- Load neuron 3 = 32'h40800000 with rate 4'b0011, then sweep -> 32'h40400000 (3.0). A second sweep -> 32'h40100000 (2.25).
- Neuron 5 = 32'h40800000 with rate 4'b1000 -> 32'h3F000000. Neuron 6 = 32'h81000000 with rate 4'b1000 -> 32'h80000000 (flush). Neuron 7 = 32'h7F800000 with any rate -> 32'h7F800000.
- in_valid, cfg_we and timestep_start asserted during busy -> in_ready=0, no stored value changes, sweep length unchanged, exactly one done.
- RESET_N low at cycle 4 of a sweep -> busy, out_valid and done drop immediately. After release, a sweep outputs INIT_POTENTIAL for all neurons.
- Rate code 4'b0110 on neuron 1 -> treated as 4'b0001. Write to address NUM_NEURONS -> ignored, and no neuron is modified.

Source files
------------

// File: rtl/potential_decay_array.sv
// Multi-neuron LIF membrane-potential store with a timestep-driven decay sweep.
// One neuron per cycle: read -> decay -> register out -> write back.
module potential_decay_array #(
  parameter int          NUM_NEURONS    = 32,
  parameter int          ADDR_W         = 5,
  parameter logic [31:0] INIT_POTENTIAL = 32'h41DED852,
  parameter logic [3:0]  DEFAULT_RATE   = 4'b0001
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              timestep_start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_potential,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [3:0]        cfg_decay_rate,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_potential
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [31:0]       r_pot  [NUM_NEURONS];
  logic [3:0]        r_rate [NUM_NEURONS];
  logic              r_out_valid, r_done;
  logic [ADDR_W-1:0] r_out_addr;
  logic [31:0]       r_out_pot;
  logic              w_last, w_in_ok, w_cfg_ok;
  logic [31:0]       w_decayed;

  // Shift-based decay: exponent decrement for 1/2^d, 3*S/4 significand trick for 0.75.
  function automatic logic [31:0] f_decay(input logic [31:0] x, input logic [3:0] r);
    logic        s;
    logic [7:0]  e, d;
    logic [23:0] sig;
    logic [25:0] t;
    logic [31:0] res;
    s   = x[31];
    e   = x[30:23];
    sig = {1'b1, x[22:0]};
    t   = {2'b00, sig} + {1'b0, sig, 1'b0};
    d   = 8'd0;
    res = x;
    if (e == 8'hFF) begin
      res = x;
    end else if (e == 8'd0) begin
      res = {s, 31'b0};
    end else begin
      case (r)
        4'b0010, 4'b0100, 4'b1000: begin
          d   = (r == 4'b0010) ? 8'd1 : (r == 4'b0100) ? 8'd2 : 8'd3;
          res = (e <= d) ? {s, 31'b0} : {s, e - d, x[22:0]};
        end
        4'b0011: begin
          if (t[25])          res = {s, e, t[24:2]};
          else if (e == 8'd1) res = {s, 31'b0};
          else                res = {s, e - 8'd1, t[23:1]};
        end
        default: res = x;
      endcase
    end
    return res;
  endfunction

  assign busy      = (r_state != S_IDLE);
  assign in_ready  = ~busy;
  assign w_last    = (r_ptr == ADDR_W'(NUM_NEURONS - 1));
  assign w_in_ok   = in_valid && !busy && (32'(in_addr) < 32'(NUM_NEURONS));
  assign w_cfg_ok  = cfg_we && !busy && (32'(cfg_addr) < 32'(NUM_NEURONS));
  assign w_decayed = f_decay(r_pot[r_ptr], r_rate[r_ptr]);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (timestep_start) w_next = S_SWEEP;
      S_SWEEP: if (w_last)         w_next = S_DRAIN;
      S_DRAIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_out_addr  <= '0;
      r_out_pot   <= '0;
    end else begin
      r_state     <= w_next;
      r_ptr       <= (r_state == S_SWEEP && !w_last) ? r_ptr + 1'b1 : '0;
      r_out_valid <= (r_state == S_SWEEP);
      r_done      <= (r_state == S_SWEEP) && w_last;
      if (r_state == S_SWEEP) begin
        r_out_addr <= r_ptr;
        r_out_pot  <= w_decayed;
      end
    end
  end

  // Writeback only happens while busy, so it never collides with an adder write.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_pot[i] <= INIT_POTENTIAL;
    end else if (r_out_valid) begin
      r_pot[r_out_addr] <= r_out_pot;
    end else if (w_in_ok) begin
      r_pot[in_addr] <= in_potential;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_rate[i] <= DEFAULT_RATE;
    end else if (w_cfg_ok) begin
      r_rate[cfg_addr] <= cfg_decay_rate;
    end
  end

  assign out_valid     = r_out_valid;
  assign done          = r_done;
  assign out_addr      = r_out_addr;
  assign out_potential = r_out_pot;

endmodule

// File: tb/tb_potential_decay_array.sv
// Scoreboard bench for potential_decay_array: sweeps push expected outputs,
// a negedge monitor pops and compares them against the DUT stream.
module tb_potential_decay_array;
  localparam int          N    = 20;
  localparam int          AW   = 5;
  localparam logic [31:0] INIT = 32'h41DED852;

  logic          CLK = 1'b0, RESET_N = 1'b0;
  logic          timestep_start = 1'b0, busy, done;
  logic          in_valid = 1'b0, in_ready;
  logic [AW-1:0] in_addr = '0;
  logic [31:0]   in_potential = '0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [3:0]    cfg_decay_rate = '0;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [31:0]   out_potential;

  always #5 CLK = ~CLK;

  potential_decay_array #(
    .NUM_NEURONS(N), .ADDR_W(AW), .INIT_POTENTIAL(INIT), .DEFAULT_RATE(4'b0001)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .timestep_start(timestep_start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_potential(in_potential),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_decay_rate(cfg_decay_rate),
    .out_valid(out_valid), .out_addr(out_addr), .out_potential(out_potential)
  );

  int checks = 0, errors = 0, done_cnt = 0;
  logic [31:0]    m_pot  [N];
  logic [3:0]     m_rate [N];
  logic [AW+31:0] sb [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Value model: scale significand by num/2^sh, renormalise, flush if exponent underflows.
  function automatic logic [31:0] ref_decay(input logic [31:0] x, input logic [3:0] r);
    int     e, ex, num, sh;
    longint sig;
    e = int'(x[30:23]);
    if (e == 255) return x;
    if (e == 0) return {x[31], 31'b0};
    num = 1; sh = 0;
    case (r)
      4'd2: sh = 1;
      4'd4: sh = 2;
      4'd8: sh = 3;
      4'd3: begin num = 3; sh = 2; end
      default: ;
    endcase
    sig = (longint'(1) << 23 | longint'(x[22:0])) * num;
    ex  = e - sh;
    while (sig >= (longint'(1) << 24)) begin sig = sig >> 1; ex++; end
    if (ex <= 0) return {x[31], 31'b0};
    return {x[31], 8'(ex), 23'(sig)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_pot[i] = INIT; m_rate[i] = 4'b0001; end
  endtask

  task automatic push_sweep();
    logic [31:0] r;
    for (int k = 0; k < N; k++) begin
      r = ref_decay(m_pot[k], m_rate[k]);
      sb.push_back({AW'(k), r});
      m_pot[k] = r;
    end
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; cfg_we = 1'b0; timestep_start = 1'b0;
  endtask

  always @(negedge CLK) begin
    logic [AW+31:0] e;
    if (RESET_N) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: addr %0d pot %h, scoreboard empty", out_addr, out_potential);
        end else begin
          e = sb.pop_front();
          check("out_addr", 64'(out_addr), 64'(e[AW+31:32]));
          check("out_potential", 64'(out_potential), 64'(e[31:0]));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_on_last", {out_valid, out_addr}, {1'b1, AW'(N - 1)});
      end
    end
  end

  task automatic sweep_check(input bit noise);
    int d0;
    d0 = done_cnt;
    for (int cyc = 1; cyc <= N + 2; cyc++) begin
      check("busy", 64'(busy), 64'(cyc <= N + 1));
      check("in_ready", 64'(in_ready), 64'(cyc > N + 1));
      if (noise && cyc <= N + 1) begin
        in_valid       = 1'($urandom_range(0, 1));
        in_addr        = AW'($urandom_range(0, N - 1));
        in_potential   = $urandom;
        cfg_we         = 1'($urandom_range(0, 1));
        cfg_addr       = AW'($urandom_range(0, N - 1));
        cfg_decay_rate = 4'($urandom_range(0, 15));
        timestep_start = 1'($urandom_range(0, 1));
      end else begin
        clear_inputs();
      end
      if (cyc < N + 2) begin @(posedge CLK); #1; end
    end
    check("done_count", 64'(done_cnt - d0), 64'd1);
    check("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  // One idle cycle of stimulus; writes land in the model before any sweep it starts.
  task automatic idle_op(input bit iv, input logic [AW-1:0] ia, input logic [31:0] ip,
                         input bit cw, input logic [AW-1:0] ca, input logic [3:0] cr,
                         input bit st, input bit noise);
    in_valid = iv; in_addr = ia; in_potential = ip;
    cfg_we = cw; cfg_addr = ca; cfg_decay_rate = cr; timestep_start = st;
    if (iv && int'(ia) < N) m_pot[ia] = ip;
    if (cw && int'(ca) < N) m_rate[ca] = cr;
    if (st) push_sweep();
    @(posedge CLK); #1;
    clear_inputs();
    if (st) sweep_check(noise);
  endtask

  task automatic sweep(input bit noise);
    idle_op(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, noise);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 5))
      0: x[30:23] = 8'd0;
      1: x[30:23] = 8'($urandom_range(1, 3));
      2: x[30:23] = 8'hFF;
      default: ;
    endcase
    return x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #22;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_out_potential", 64'(out_potential), 64'd0);
    @(negedge CLK); RESET_N = 1'b1;
    @(posedge CLK); #1;

    // Halve neuron 0; everything else passes through at rate 1.
    idle_op(1'b0, '0, '0, 1'b1, 5'd0, 4'b0010, 1'b0, 1'b0);
    sweep(1'b0);
    check("n0_after_halve", 64'(m_pot[0]), 64'h415ED852);

    // Directed arithmetic cases plus out-of-range and unknown rate code.
    idle_op(1'b1, 5'd3, 32'h40800000, 1'b1, 5'd3, 4'b0011, 1'b0, 1'b0);
    idle_op(1'b1, 5'd5, 32'h40800000, 1'b1, 5'd5, 4'b1000, 1'b0, 1'b0);
    idle_op(1'b1, 5'd6, 32'h81000000, 1'b1, 5'd6, 4'b1000, 1'b0, 1'b0);
    idle_op(1'b1, 5'd7, 32'h7F800000, 1'b1, 5'd7, 4'b0011, 1'b0, 1'b0);
    idle_op(1'b0, '0, '0, 1'b1, 5'd1, 4'b0110, 1'b0, 1'b0);
    idle_op(1'b1, 5'd20, 32'h12345678, 1'b1, 5'd20, 4'b1000, 1'b0, 1'b0);
    idle_op(1'b1, 5'd31, 32'h00000000, 1'b1, 5'd31, 4'b0100, 1'b0, 1'b0);
    // Same-cycle potential write, rate write and start on neuron 4.
    idle_op(1'b1, 5'd4, 32'hC0000000, 1'b1, 5'd4, 4'b0100, 1'b1, 1'b0);
    check("n3_first", 64'(m_pot[3]), 64'h40400000);
    check("n5_div8", 64'(m_pot[5]), 64'h3F000000);
    check("n6_flush", 64'(m_pot[6]), 64'h80000000);
    check("n7_inf", 64'(m_pot[7]), 64'h7F800000);
    // Second sweep with write/cfg/start noise during busy.
    sweep(1'b1);
    check("n3_second", 64'(m_pot[3]), 64'h40100000);

    // Reset in cycle 4 of a sweep aborts it.
    timestep_start = 1'b1;
    @(posedge CLK); #1;
    timestep_start = 1'b0;
    push_sweep();
    repeat (3) begin @(posedge CLK); #1; end
    RESET_N = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    sb.delete();
    model_reset();
    @(negedge CLK); RESET_N = 1'b1;
    @(posedge CLK); #1;
    sweep(1'b0);

    for (int round = 0; round < 8; round++) begin
      for (int w = 0; w < int'($urandom_range(1, 6)); w++)
        idle_op(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), rand_fp(),
                1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
                1'b0, 1'b0);
      sweep(1'(round % 2));
    end

    repeat (3) @(posedge CLK);
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
